spi_mem_master: RTL and testbench

Single-lane SPI master that issues memory write and read transactions to the PULPino SPI slave (`spi_cs_i`, `spi_clk_i`, `spi_sdi0_i`, `spi_sdo0_o`) in standard mode. It is the initiator end of the chip's SPI load port. It sits in the test/FPGA harness and drives the pad-level SPI pins, so a host-side request/response interface can load program memory and read back from it.

---
 rtl/spi_mem_master.sv | 137 +++++++++++++
 tb/tb_spi_mem_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_master.sv
// Single-lane SPI mode-0 master issuing memory write/read frames
// to the PULPino SPI slave load port.
module spi_mem_master #(
  parameter int CLK_DIV      = 4,
  parameter int DUMMY_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_clk_o,
  output logic        spi_cs_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
);

  localparam int N_WR = 72;
  localparam int N_RD = 72 + DUMMY_CYCLES;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N_RD + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] WR_LAST  = BW'(N_WR - 1);
  localparam logic [BW-1:0] RD_LAST  = BW'(N_RD - 1);
  localparam logic [7:0]    CMD_WR   = 8'h02;
  localparam logic [7:0]    CMD_RD   = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_last;
  logic [71:0]     tx_sr;
  logic [31:0]     rx_sr;
  logic            is_write;
  logic            tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      bit_last  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      is_write  <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_clk_o <= 1'b0;
      spi_cs_o  <= 1'b1;
      spi_sdo_o <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state != S_IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            state     <= S_SETUP;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            bit_last  <= req_write ? WR_LAST : RD_LAST;
            is_write  <= req_write;
            rx_sr     <= '0;
            tx_sr     <= req_write ?
                         {CMD_WR, req_addr, req_wdata} :
                         {CMD_RD, req_addr, 32'h0};
            spi_sdo_o <= 1'b0;
            spi_cs_o  <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_SETUP: begin
          if (tick) begin
            state     <= S_SHIFT;
            spi_clk_o <= 1'b1;
            rx_sr     <= {rx_sr[30:0], spi_sdi_i};
          end
        end
        S_SHIFT: begin
          if (tick) begin
            if (spi_clk_o) begin
              spi_clk_o <= 1'b0;
              if (bit_cnt == bit_last) begin
                state     <= S_HOLD;
                spi_sdo_o <= 1'b0;
              end else begin
                bit_cnt   <= bit_cnt + 1'b1;
                spi_sdo_o <= tx_sr[70];
                tx_sr     <= {tx_sr[70:0], 1'b0};
              end
            end else begin
              spi_clk_o <= 1'b1;
              rx_sr     <= {rx_sr[30:0], spi_sdi_i};
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            state     <= S_GAP;
            spi_cs_o  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= is_write ? 32'h0 : rx_sr;
          end
        end
        S_GAP: begin
          if (tick) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Scoreboard bench for spi_mem_master: a default instance and a
// CLK_DIV=1 / DUMMY_CYCLES=0 instance share one SPI slave model.
module tb_spi_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        miso = 1'b0;

  logic        rdy0, rdy1, rv0, rv1, bsy0, bsy1;
  logic        sck0, sck1, cs0, cs1, sdo0, sdo1;
  logic [31:0] rd0, rd1;

  logic        req_ready, rsp_valid, busy;
  logic        spi_clk, spi_cs, spi_sdo;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  spi_mem_master u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv0),
    .rsp_rdata(rd0), .busy(bsy0),
    .spi_clk_o(sck0), .spi_cs_o(cs0),
    .spi_sdo_o(sdo0), .spi_sdi_i(miso)
  );

  spi_mem_master #(.CLK_DIV(1), .DUMMY_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv1),
    .rsp_rdata(rd1), .busy(bsy1),
    .spi_clk_o(sck1), .spi_cs_o(cs1),
    .spi_sdo_o(sdo1), .spi_sdi_i(miso)
  );

  assign req_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? rv1 : rv0;
  assign rsp_rdata = sel ? rd1 : rd0;
  assign busy      = sel ? bsy1 : bsy0;
  assign spi_clk   = sel ? sck1 : sck0;
  assign spi_cs    = sel ? cs1 : cs0;
  assign spi_sdo   = sel ? sdo1 : sdo0;

  typedef struct {
    bit          sel;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          t;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // slave model
  logic [127:0] sh;
  int           nb;
  logic [31:0]  slave_rd = '0;
  int           cur_div, cur_dm;

  assign cur_div = sel ? 1 : 4;
  assign cur_dm  = sel ? 0 : 32;

  always @(negedge spi_cs) begin
    sh = '0;
    nb = 0;
    miso = 1'b0;
  end

  always @(posedge spi_clk) begin
    sh = {sh[126:0], spi_sdo};
    nb++;
  end

  always @(negedge spi_clk) begin
    int idx;
    idx = nb - 40 - cur_dm;
    if (idx >= 0 && idx < 32) miso = slave_rd[31 - idx];
    else miso = 1'b0;
  end

  // response checker
  int   cs_lo = 0, cs_hi = 0, last_lo = 0, rdy_t = -1;
  logic cs_prev = 1'b1;
  bit   chk_pulse = 1'b0;

  always @(negedge clk) begin
    exp_t         e;
    int           n, dv;
    logic [7:0]   cmd_v;
    logic [31:0]  addr_v;
    logic [127:0] m;
    if (!spi_cs) begin
      if (cs_prev) chk("cs_gap", 64'(cs_hi >= cur_div), 64'd1);
      cs_lo++;
      cs_hi = 0;
    end else begin
      if (!cs_prev) last_lo = cs_lo;
      cs_lo = 0;
      cs_hi++;
    end
    cs_prev = spi_cs;
    if (chk_pulse) chk("rsp_pulse", 64'(rsp_valid), 64'd0);
    chk_pulse = 1'b0;
    if (rdy_t >= 0 && cyc == rdy_t - 1)
      chk("busy_hold", 64'({req_ready, busy}), 64'b01);
    if (rdy_t >= 0 && cyc == rdy_t)
      chk("ready_ret", 64'({req_ready, busy}), 64'b10);
    if (rsp_valid) begin
      chk_pulse = 1'b1;
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        dv = e.sel ? 1 : 4;
        n = 72 + (e.wr ? 0 : (e.sel ? 0 : 32));
        cmd_v = 8'(sh >> (n - 8));
        addr_v = 32'(sh >> (n - 40));
        m = (128'd1 << (n - 40)) - 128'd1;
        chk("rsp_cyc", 64'(cyc), 64'(e.t + 1 + (2*n + 1)*dv));
        chk("rdata", 64'(rsp_rdata), e.wr ? 64'd0 : 64'(e.rdata));
        chk("nbits", 64'(nb), 64'(n));
        chk("cs_low", 64'(last_lo), 64'((2*n + 1)*dv));
        chk("cmd", 64'(cmd_v), e.wr ? 64'h02 : 64'h0B);
        chk("addr", 64'(addr_v), 64'(e.addr));
        chk("tail", 64'(sh & m), e.wr ? 64'(e.wdata) : 64'd0);
        rdy_t = e.t + 1 + (2*n + 2)*dv;
      end
    end
  end

  task automatic do_req(input bit s, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input bit hold,
                        input bit scram, output int t);
    exp_t e;
    bit   got;
    @(negedge clk);
    sel = s;
    slave_rd = rd;
    req_write = wr;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    got = 1'b0;
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (req_valid && req_ready) begin
        got = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.sel = s; e.wr = wr; e.addr = a;
    e.wdata = d; e.rdata = rd; e.t = t;
    exp_q.push_back(e);
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    if (scram) begin
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        req_addr = $urandom;
        req_wdata = $urandom;
        req_write = ~req_write;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(spi_cs), 64'd1);
    chk("rst_sck", 64'(spi_clk), 64'd0);
    chk("rst_sdo", 64'(spi_sdo), 64'd0);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_req(0, 1, 32'h0000_1000, 32'hA5A5_0F0F, 32'h0, 0, 0, t);
    drain();
    do_req(0, 0, 32'h0010_0000, 32'h0, 32'hDEAD_BEEF, 0, 0, t);
    drain();

    do_req(0, 1, 32'h0000_2000, 32'h1111_2222, 32'h0, 1, 0, t1);
    do_req(0, 1, 32'h0000_2004, 32'h3333_4444, 32'h0, 0, 0, t2);
    chk("b2b_accept", 64'(t2), 64'(t1 + 585));
    drain();

    do_req(0, 0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 0, t);
    while (cyc < t + 320) @(negedge clk);
    chk("pre_rst_sck", 64'(spi_clk), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 64'(spi_cs), 64'd1);
    chk("mid_rst_sck", 64'(spi_clk), 64'd0);
    chk("mid_rst_sdo", 64'(spi_sdo), 64'd0);
    chk("mid_rst_busy", 64'({req_ready, busy}), 64'b10);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    do_req(0, 1, 32'h0000_3000, 32'h5A5A_F0F0, 32'h0, 0, 0, t);
    drain();

    do_req(1, 0, 32'h0000_0080, 32'h0, 32'h1234_5678, 0, 0, t);
    drain();
    do_req(1, 1, 32'h8000_0001, 32'hFFFF_0000, 32'h0, 0, 0, t);
    drain();

    do_req(0, 1, 32'hCAFE_0004, 32'h0BAD_F00D, 32'h0, 0, 1, t);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
